// File: rtl/micro_seq_if.sv
// Bus bundle between the micro-sequencer, its microcode ROM and the
// microinstruction decoder. Sequencer side uses the slave modport.
interface micro_seq_if #(
    parameter int AW = 6
);
    logic          start;
    logic          stall;
    logic [3:0]    flags;
    logic [AW-1:0] rom_addr;
    logic [8:0]    rom_data;
    logic [8:0]    ir;
    logic          ir_valid;
    logic          busy;
    logic          halted;
    logic          err;

    modport master (
        output start, stall, flags, rom_data,
        input  rom_addr, ir, ir_valid, busy, halted, err
    );

    modport slave (
        input  start, stall, flags, rom_data,
        output rom_addr, ir, ir_valid, busy, halted, err
    );
endinterface

// File: rtl/micro_seq.sv
// Microprogram sequencer driving a synchronous microcode ROM.
// Define SEQ_CALL_EN to add the one-level CALL/RET return register.
module micro_seq #(
    parameter int            AW       = 6,
    parameter logic [AW-1:0] RST_ADDR = '0
) (
    input logic        clk,
    input logic        rst_n,
    micro_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        EXEC   = 3'd3,
        TFETCH = 3'd4,
        TLOAD  = 3'd5,
        HALT   = 3'd6
    } state_e;

    localparam logic [2:0] OP_BRANCH = 3'b111;
    localparam logic [2:0] COND_HALT = 3'b111;

    state_e        state_q;
    logic [AW-1:0] upc_q;
    logic [AW-1:0] rom_addr_q;
    logic [8:0]    ir_q;
    logic [3:0]    flag_q;
    logic          ir_valid_q;
    logic          busy_q;
    logic          halted_q;

    logic [AW-1:0] upc_p1;
    logic [AW-1:0] upc_p2;
    logic [AW-1:0] target;
    logic [AW-1:0] tload_upc;
    logic          taken;
    logic          is_branch;
    logic          is_halt;

`ifdef SEQ_CALL_EN
    localparam logic [8:0] RET_WORD = 9'b000_111111;

    logic [AW-1:0] ret_addr_q;
    logic          ret_v_q;
    logic          err_q;
    logic          is_ret;
    logic          is_call;

    assign is_ret  = (ir_q == RET_WORD);
    assign is_call = (ir_q[2:0] == 3'b000);
`endif

    // Address arithmetic deliberately wraps modulo 2^AW.
    assign upc_p1    = upc_q + AW'(1);
    assign upc_p2    = upc_q + AW'(2);
    assign target    = bus.rom_data[AW-1:0];
    assign is_branch = (ir_q[8:6] == OP_BRANCH);
    assign is_halt   = is_branch && (ir_q[2:0] == COND_HALT);

    // flag_q is {Z,N,C,V}, captured during EXEC of the branch word.
    always_comb begin
        // NOTE: default assigned first so this block cannot infer a latch.
        taken = 1'b0;
        case (ir_q[2:0])
            3'b000: begin
`ifdef SEQ_CALL_EN
                taken = 1'b1;
`else
                taken = 1'b0;
`endif
            end
            3'b001:  taken = 1'b1;
            3'b010:  taken = flag_q[3];
            3'b011:  taken = !flag_q[3];
            3'b100:  taken = flag_q[2];
            3'b101:  taken = flag_q[1];
            3'b110:  taken = flag_q[0];
            default: taken = 1'b0;
        endcase
    end

    assign tload_upc = taken ? target : upc_p2;

    // NOTE: only non-blocking assignments here, so every register sees
    // pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            upc_q      <= RST_ADDR;
            rom_addr_q <= RST_ADDR;
            ir_q       <= 9'h000;
            flag_q     <= 4'h0;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
`ifdef SEQ_CALL_EN
            ret_addr_q <= '0;
            ret_v_q    <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else if (!bus.stall) begin
            case (state_q)
                IDLE, HALT: begin
                    if (bus.start) begin
                        state_q    <= FETCH;
                        upc_q      <= RST_ADDR;
                        rom_addr_q <= RST_ADDR;
                        busy_q     <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    ir_q       <= bus.rom_data;
                    ir_valid_q <= 1'b1;
                    state_q    <= EXEC;
                end
                EXEC: begin
                    ir_valid_q <= 1'b0;
                    flag_q     <= bus.flags;
`ifdef SEQ_CALL_EN
                    if (is_ret) begin
                        if (ret_v_q) begin
                            upc_q      <= ret_addr_q;
                            rom_addr_q <= ret_addr_q;
                            ret_v_q    <= 1'b0;
                            state_q    <= FETCH;
                        end else begin
                            err_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                    end else
`endif
                    if (!is_branch) begin
                        upc_q      <= upc_p1;
                        rom_addr_q <= upc_p1;
                        state_q    <= FETCH;
                    end else if (is_halt) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        rom_addr_q <= upc_p1;
                        state_q    <= TFETCH;
                    end
                end
                TFETCH: state_q <= TLOAD;
                TLOAD: begin
                    upc_q      <= tload_upc;
                    rom_addr_q <= tload_upc;
                    state_q    <= FETCH;
`ifdef SEQ_CALL_EN
                    if (is_call) begin
                        ret_addr_q <= upc_p2;
                        ret_v_q    <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q    <= IDLE;
                    ir_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.ir       = ir_q;
    // The decoder must never act on a frozen instruction.
    assign bus.ir_valid = ir_valid_q && !bus.stall;
    assign bus.busy     = busy_q;
    assign bus.halted   = halted_q;
`ifdef SEQ_CALL_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_micro_seq.sv
// Directed bench for micro_seq with a synchronous ROM model.
// Build with +define+SEQ_CALL_EN to exercise CALL/RET.
module tb_micro_seq;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [8:0] rom [64];
    logic [5:0] trace_q [$];

    micro_seq_if #(.AW(6)) bus ();

    micro_seq #(.AW(6), .RST_ADDR(6'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench in the middle of cycle 1 (the FETCH after the start edge).
    task automatic go();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!bus.halted && n < 40) begin
            step(1);
            n++;
        end
        checks++;
        if (bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL wait_halt: halted=%b required 1", bus.halted);
        end
    endtask

    task automatic capture_trace();
        int n = 0;
        trace_q.delete();
        go();
        trace_q.push_back(bus.rom_addr);
        while (!bus.halted && n < 80) begin
            step(1);
            if (bus.rom_addr !== trace_q[$]) trace_q.push_back(bus.rom_addr);
            n++;
        end
        checks++;
        if (bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL trace_halt: halted=%b required 1", bus.halted);
        end
    endtask

    task automatic compare_trace(input string name, input logic [5:0] exp_q [$]);
        checks++;
        if (trace_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d addresses required %0d", name, trace_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (trace_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s[%0d]: rom_addr=%h required %h", name, i, trace_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus.rom_addr !== 6'h00 || bus.ir !== 9'h000 || bus.ir_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: addr=%h ir=%h v=%b busy=%b halt=%b err=%b required 00 000 0 0 0 0",
                     bus.rom_addr, bus.ir, bus.ir_valid, bus.busy, bus.halted, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        checks++;
        if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b halted=%b ir_valid=%b required 0 0 0",
                     bus.busy, bus.halted, bus.ir_valid);
        end
    endtask

    task automatic test_straight_line();
        logic [10:1] iv;
        rom[0] = 9'h040;
        rom[1] = 9'h080;
        rom[2] = 9'h1F7;
        go();
        iv[1] = bus.ir_valid;
        checks++;
        if (bus.rom_addr !== 6'h00 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL straight_fetch0: addr=%h busy=%b required 00 1", bus.rom_addr, bus.busy);
        end
        for (int c = 2; c <= 10; c++) begin
            step(1);
            iv[c] = bus.ir_valid;
            if (c == 3) begin
                checks++;
                if (bus.ir !== 9'h040) begin
                    errors++;
                    $display("FAIL straight_ir0: ir=%h required 040", bus.ir);
                end
            end
        end
        checks++;
        if (iv !== 10'b0100100100) begin
            errors++;
            $display("FAIL straight_ir_valid: cycles=%b required 0100100100", iv);
        end
        checks++;
        if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.rom_addr !== 6'h02) begin
            errors++;
            $display("FAIL straight_halt: halted=%b busy=%b addr=%h required 1 0 02",
                     bus.halted, bus.busy, bus.rom_addr);
        end
    endtask

    task automatic run_branch(input logic [2:0] cond, input logic [3:0] fl,
                              output logic [5:0] fetch_addr);
        rom[0]     = {3'b111, 3'b000, cond};
        rom[1]     = 9'h020;
        rom[2]     = 9'h1F7;
        rom[6'h20] = 9'h1F7;
        go();
        step(2);
        bus.flags = fl;
        step(1);
        bus.flags = ~fl;
        step(2);
        fetch_addr = bus.rom_addr;
        bus.flags = 4'h0;
        wait_halt();
    endtask

    task automatic test_branch_conditions();
        logic [2:0] conds [9] = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b001};
        logic [3:0] fls   [9] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b1101, 4'b0001, 4'b0000};
        logic [5:0] exps  [9] = '{6'h20, 6'h02, 6'h20, 6'h02, 6'h20, 6'h20, 6'h02, 6'h20, 6'h20};
        logic [5:0] got;
        for (int i = 0; i < 9; i++) begin
            run_branch(conds[i], fls[i], got);
            checks++;
            if (got !== exps[i]) begin
                errors++;
                $display("FAIL branch_cond%0d: cond=%b flags=%b fetch=%h required %h",
                         i, conds[i], fls[i], got, exps[i]);
            end
        end
    endtask

    task automatic test_stall();
        rom[0] = 9'h040;
        rom[1] = 9'h1F7;
        go();
        step(1);
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++;
            if (bus.rom_addr !== 6'h00 || bus.ir !== 9'h1F7 || bus.ir_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_load%0d: addr=%h ir=%h v=%b busy=%b required 00 1f7 0 1",
                         i, bus.rom_addr, bus.ir, bus.ir_valid, bus.busy);
            end
        end
        bus.stall = 1'b0;
        step(1);
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.ir !== 9'h040) begin
            errors++;
            $display("FAIL stall_resume: v=%b ir=%h required 1 040", bus.ir_valid, bus.ir);
        end
        bus.stall = 1'b1;
        #1;
        checks++;
        if (bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_exec_mask: ir_valid=%b required 0", bus.ir_valid);
        end
        step(1);
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.rom_addr !== 6'h00) begin
            errors++;
            $display("FAIL stall_exec_hold: v=%b addr=%h required 0 00", bus.ir_valid, bus.rom_addr);
        end
        bus.stall = 1'b0;
        step(1);
        checks++;
        if (bus.rom_addr !== 6'h01 || bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_next_fetch: addr=%h v=%b required 01 0", bus.rom_addr, bus.ir_valid);
        end
        wait_halt();
    endtask

    task automatic test_wrap_and_busy_start();
        rom[0]     = 9'h1C1;
        rom[1]     = 9'h03F;
        rom[6'h3F] = 9'h040;
        go();
        step(1);
        rom[0] = 9'h1F7;
        step(2);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(1);
        checks++;
        if (bus.rom_addr !== 6'h3F) begin
            errors++;
            $display("FAIL start_ignored_busy: addr=%h required 3f", bus.rom_addr);
        end
        step(3);
        checks++;
        if (bus.rom_addr !== 6'h00) begin
            errors++;
            $display("FAIL wrap_fetch: addr=%h required 00", bus.rom_addr);
        end
        wait_halt();
    endtask

    task automatic test_reset_mid_branch();
        rom[0] = 9'h1C1;
        rom[1] = 9'h020;
        go();
        step(3);
        checks++;
        if (bus.rom_addr !== 6'h01 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL tfetch_addr: addr=%h busy=%b required 01 1", bus.rom_addr, bus.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rom_addr !== 6'h00 || bus.ir !== 9'h000 || bus.ir_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_branch: addr=%h ir=%h v=%b busy=%b halt=%b err=%b required 00 000 0 0 0 0",
                     bus.rom_addr, bus.ir, bus.ir_valid, bus.busy, bus.halted, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        checks++;
        if (bus.busy !== 1'b0 || bus.rom_addr !== 6'h00) begin
            errors++;
            $display("FAIL idle_after_mid_reset: busy=%b addr=%h required 0 00", bus.busy, bus.rom_addr);
        end
        rom[0] = 9'h040;
        rom[1] = 9'h1F7;
        go();
        checks++;
        if (bus.rom_addr !== 6'h00 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_fetch: addr=%h busy=%b required 00 1", bus.rom_addr, bus.busy);
        end
        step(2);
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.ir !== 9'h040) begin
            errors++;
            $display("FAIL restart_exec: v=%b ir=%h required 1 040", bus.ir_valid, bus.ir);
        end
        wait_halt();
    endtask

`ifdef SEQ_CALL_EN
    task automatic test_call_ret();
        for (int i = 0; i < 4; i++) rom[i] = 9'h040;
        rom[4]     = 9'h1C0;
        rom[5]     = 9'h010;
        rom[6'h10] = 9'h03F;
        rom[6]     = 9'h03F;
        capture_trace();
        compare_trace("call_trace", '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h10, 6'h06});
        checks++;
        if (bus.err !== 1'b1 || bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL ret_underflow: err=%b halted=%b required 1 1", bus.err, bus.halted);
        end
    endtask
`else
    task automatic test_skip_nop();
        rom[0] = 9'h1C0;
        rom[1] = 9'h010;
        rom[2] = 9'h03F;
        rom[3] = 9'h1F7;
        capture_trace();
        compare_trace("skip_trace", '{6'h00, 6'h01, 6'h02, 6'h03});
        checks++;
        if (bus.err !== 1'b0 || bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL nop_no_err: err=%b halted=%b required 0 1", bus.err, bus.halted);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 9'h1F7;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.flags = 4'h0;
        test_reset();
        test_straight_line();
        test_branch_conditions();
        test_stall();
        test_wrap_and_busy_start();
        test_reset_mid_branch();
`ifdef SEQ_CALL_EN
        test_call_ret();
`else
        test_skip_nop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
